triangle_setup_ctrl: RTL
========================

// Module: triangle_setup_ctrl
// PURPOSE
// Sequences screen-space triangles through the shared triangle_area pipeline (fixed latency, no backpressure).
// - Issues a triangle only when a downstream slot is guaranteed for its result.
// - Pairs each returned area with the triangle's vertices.
// - Applies winding/degenerate culling.
// - Presents surviving triangles, with area and winding, to the rasterizer setup stage over valid/ready.
// PARAMETERS
// AREA_LATENCY  4  cycles from area_valid_out to area_valid_in; must match the area unit
// OUT_DEPTH     8  output FIFO entries (power of 2, >= AREA_LATENCY)
// PORTS
// clk_in            in   1         system clock
// rst_in            in   1         synchronous, active-high reset
// valid_in          in   1         upstream triangle valid
// ready_out         out  1         upstream ready; accept = valid_in & ready_out
// vertices_in       in   [2:0][1:0][16:0]  (x,y) per vertex, unsigned [9].[8]
// cull_mode_in      in   2         0 none, 1 cull negative, 2 cull positive, 3 cull both (zero-area only)
// area_valid_out    out  1         issue strobe to area unit
// area_vertices_out out  [2:0][1:0][16:0]  vertices to area unit
// area_valid_in     in   1         area unit result strobe
// area_negative_in  in   1         area unit sign
// area_in           in   34        area unit magnitude [18].[16]
// valid_out         out  1         triangle available to rasterizer
// ready_in          in   1         rasterizer ready; pop = valid_out & ready_in
// vertices_out      out  [2:0][1:0][16:0]  surviving triangle vertices
// negative_out      out  1         winding flag of head entry
// area_out          out  34        area of head entry
// cull_count_out    out  32        culled triangles since reset, wraps at 2^32
// error_out         out  1         sticky: result with no pending entry
// BEHAVIOUR
// - Reset values: ready_out=0, area_valid_out=0, valid_out=0, cull_count_out=0, error_out=0.
//   All FIFOs are empty and inflight=0. ready_out rises the first cycle after reset deasserts.
// - Credit rule: ready_out = (inflight + out_count) < OUT_DEPTH.
//   - Combinational from registered counts only.
//   - A pop in cycle N raises ready_out no earlier than N+1.
// - Accept:
//   - The same cycle drives area_valid_out=1 and area_vertices_out=vertices_in, combinationally.
//   - Pushes {vertices, cull_mode_in} into the pending FIFO (depth AREA_LATENCY+1).
//   - inflight++.
// - cull_mode_in is sampled per triangle at accept. Changing it mid-stream affects only later triangles.
// - Result (area_valid_in):
//   - Pops the head of the pending FIFO; results return in issue order.
//   - inflight--.
//   - Cull when: area_in==0 and mode!=0; or mode bit0 & negative; or mode bit1 & !negative & area!=0.
//   - Culled: cull_count_out++ next cycle; no output push.
//   - Not culled: push {vertices, negative, area} into the output FIFO.
// - Simultaneous accept and result in one cycle: inflight is unchanged; both FIFO ops take effect.
// - Simultaneous output push and pop: out_count is unchanged. Push into a full output FIFO is impossible by the credit rule.
// - area_valid_in with pending FIFO empty: ignore the data, set error_out (sticky until reset).
// - Output FIFO is first-word-fall-through: valid_out = !empty, head fields stable while valid_out & !ready_in.
// - Latency: accept in cycle N -> area_valid_in at N+AREA_LATENCY -> valid_out at N+AREA_LATENCY+1 (empty FIFO).
// - Reset mid-operation: all state is flushed. The area unit shares rst_in, so no stale results return.
// STRUCTURE
// - Shared package graphics_pkg:
//   - vertex2d_t (17-bit x,y)
//   - triangle2d_t ([2:0] vertex2d_t)
//   - cull_mode_e
//   - AREA_W=34
// - Sub-module sync_fifo (parameterised WIDTH/DEPTH, FWFT, count output). Instantiated twice: pending and output.
// - Credit counter and cull decision live in this module. triangle_area is instantiated by the parent, not here.
// TESTING
// - Single tri (0,0),(10,0),(0,10) [x256], mode 0:
//   - area_out=3276800 (50.0), negative_out=1.
//   - valid_out exactly 5 cycles after accept.
// - Same tri, mode 1: no valid_out, cull_count_out=1.
//   - Swap v1/v2: passes with negative_out=0.
// - Degenerate tri (0,0),(5,5),(10,10), mode 1: culled. Mode 0: passes with area_out=0.
// - ready_in held 0, 20 back-to-back triangles offered:
//   - Exactly 8 accepted, then ready_out=0.
//   - Release ready_in: all 20 emerge in order, none lost.
// - Toggle mode 0->1 between consecutive accepts: first triangle uses mode 0, second uses mode 1.
// - Spurious area_valid_in with nothing pending -> error_out=1.
//   - Reset mid-burst -> all outputs at reset values, cull_count_out=0, then normal operation resumes.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared screen-space geometry types for the triangle setup path.
// Vertex coordinates are unsigned [9].[8] fixed point; areas are [18].[16] magnitudes.
package graphics_pkg;

    localparam int COORD_W = 17;
    localparam int AREA_W  = 34;

    // y sits in the upper half so that x occupies index [0] of a [1:0][16:0] view
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } vertex2d_t;

    typedef vertex2d_t [2:0] triangle2d_t;

    typedef enum logic [1:0] {
        CULL_NONE = 2'd0,
        CULL_NEG  = 2'd1,
        CULL_POS  = 2'd2,
        CULL_BOTH = 2'd3
    } cull_mode_e;

    typedef struct packed {
        triangle2d_t verts;
        cull_mode_e  mode;
    } pending_entry_t;

    typedef struct packed {
        triangle2d_t       verts;
        logic              negative;
        logic [AREA_W-1:0] area;
    } result_entry_t;

    function automatic logic cull_decide(input cull_mode_e        mode,
                                         input logic              negative,
                                         input logic [AREA_W-1:0] area);
        logic [1:0] m;
        logic       zero_area;
        m         = mode;
        zero_area = (area == {AREA_W{1'b0}});
        return (zero_area && (m != 2'd0)) ||
               (m[0] && negative) ||
               (m[1] && !negative && !zero_area);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/triangle_setup_ctrl.sv
// Issues triangles to the shared area unit under a credit scheme, pairs results with
// their vertices, applies winding/degenerate culling and queues survivors for setup.
module triangle_setup_ctrl
    import graphics_pkg::*;
#(
    parameter int AREA_LATENCY = 4,
    parameter int OUT_DEPTH    = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [2:0][1:0][16:0]   vertices_in,
    input  logic [1:0]              cull_mode_in,
    output logic                    area_valid_out,
    output logic [2:0][1:0][16:0]   area_vertices_out,
    input  logic                    area_valid_in,
    input  logic                    area_negative_in,
    input  logic [AREA_W-1:0]       area_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [2:0][1:0][16:0]   vertices_out,
    output logic                    negative_out,
    output logic [AREA_W-1:0]       area_out,
    output logic [31:0]             cull_count_out,
    output logic                    error_out
);

    localparam int PEND_DEPTH = AREA_LATENCY + 1;
    localparam int PEND_CNT_W = $clog2(PEND_DEPTH + 1);
    localparam int CNT_W      = $clog2(OUT_DEPTH + 1);
    localparam int PEND_W     = $bits(pending_entry_t);
    localparam int RES_W      = $bits(result_entry_t);

    logic                  alive_q;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [31:0]           cull_count_q, cull_count_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic                  result_hit;
    logic                  culled;
    logic                  out_push;
    logic                  out_pop;
    logic [CNT_W:0]        credit_sum;

    pending_entry_t        pend_in;
    pending_entry_t        pend_head;
    logic                  pend_empty;
    logic                  pend_full;
    logic [PEND_CNT_W-1:0] pend_count;

    result_entry_t         out_in;
    result_entry_t         out_head;
    logic                  out_empty;
    logic                  out_full;
    logic [CNT_W-1:0]      out_count;

    logic                  unused_ok;

    sync_fifo #(
        .WIDTH (PEND_W),
        .DEPTH (PEND_DEPTH)
    ) u_pending_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (accept),
        .data_i  (pend_in),
        .pop_i   (result_hit),
        .data_o  (pend_head),
        .empty_o (pend_empty),
        .full_o  (pend_full),
        .count_o (pend_count)
    );

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_output_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (out_push),
        .data_i  (out_in),
        .pop_i   (out_pop),
        .data_o  (out_head),
        .empty_o (out_empty),
        .full_o  (out_full),
        .count_o (out_count)
    );

    // Every in-flight triangle already owns an output slot, so a result can always be stored.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, out_count};
    assign ready_out  = alive_q && (credit_sum < (CNT_W+1)'(OUT_DEPTH)) && !pend_full;

    assign area_valid_out    = accept;
    assign area_vertices_out = vertices_in;

    assign valid_out      = !out_empty;
    assign vertices_out   = out_head.verts;
    assign negative_out   = out_head.negative;
    assign area_out       = out_head.area;
    assign cull_count_out = cull_count_q;
    assign error_out      = error_q;

    assign unused_ok = ^{pend_count, out_full};

    always_comb begin
        accept         = valid_in && ready_out;
        pend_in.verts  = triangle2d_t'(vertices_in);
        pend_in.mode   = cull_mode_e'(cull_mode_in);

        result_hit     = area_valid_in && !pend_empty;
        culled         = result_hit && cull_decide(pend_head.mode, area_negative_in, area_in);
        out_push       = result_hit && !culled;
        out_in.verts    = pend_head.verts;
        out_in.negative = area_negative_in;
        out_in.area     = area_in;
        out_pop        = !out_empty && ready_in;

        case ({accept, result_hit})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (culled) begin
            cull_count_d = cull_count_q + 32'd1;
        end else begin
            cull_count_d = cull_count_q;
        end

        // A result with nothing pending is orphaned data; flag it and drop it.
        if (area_valid_in && pend_empty) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alive_q      <= 1'b0;
            inflight_q   <= {CNT_W{1'b0}};
            cull_count_q <= 32'd0;
            error_q      <= 1'b0;
        end else begin
            alive_q      <= 1'b1;
            inflight_q   <= inflight_d;
            cull_count_q <= cull_count_d;
            error_q      <= error_d;
        end
    end

endmodule
